// File: rtl/count_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_game_ctrl
// Brief    : Counting-game round sequencer. It produces an LFSR target and
//            runs the show/answer/judge/result phases over ROUNDS rounds.
//            Define COUNT_GAME_TIMEOUT_EN to enable the answer timeout.
// Revision : 1.0 - initial release
// ============================================================================
module count_game_ctrl #(
    parameter int TICK_DIV     = 1000,
    parameter int SHOW_TICKS   = 3,
    parameter int ANSWER_TICKS = 10,
    parameter int RESULT_TICKS = 2,
    parameter int ROUNDS       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] sw,
    output logic [6:0] target,
    output logic       show,
    output logic [3:0] timer,
    output logic [2:0] round,
    output logic [3:0] score,
    output logic       ok,
    output logic       bad,
    output logic       beep,
    output logic       over,
    output logic [2:0] state
);
    localparam int                  c_tick_w       = $clog2(TICK_DIV);
    localparam logic [c_tick_w-1:0] c_tick_last    = c_tick_w'(TICK_DIV - 1);
    localparam logic [7:0]          c_show_last    = 8'(SHOW_TICKS - 1);
    localparam logic [7:0]          c_result_last  = 8'(RESULT_TICKS - 1);
    localparam logic [3:0]          c_answer_ticks = 4'(ANSWER_TICKS);
    localparam logic [2:0]          c_rounds       = 3'(ROUNDS);
    localparam logic [6:0]          c_lfsr_seed    = 7'h5A;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHOW   = 3'd1,
        S_ANSWER = 3'd2,
        S_JUDGE  = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t              r_state, w_state;
    logic                r_start_q;
    logic [6:0]          r_lfsr;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [7:0]          r_ph_cnt, w_ph_cnt;
    logic [6:0]          r_answer, w_answer;
    logic                r_timeout, w_timeout;
    logic [6:0]          r_target, w_target;
    logic                r_show;
    logic [3:0]          r_timer, w_timer;
    logic [2:0]          r_round, w_round;
    logic [3:0]          r_score, w_score;
    logic                r_ok, w_ok;
    logic                r_bad, w_bad;
    logic                r_beep, w_beep;
    logic                r_over, w_over;

    logic                w_st_e;
    logic                w_tick;
    logic [6:0]          w_new_target;

    // start_q resets high so a key held through reset never counts as a press
    assign w_st_e       = start & ~r_start_q;
    assign w_tick       = (r_tick_cnt == c_tick_last);
    assign w_new_target = {1'b0, r_lfsr[5:0]} + 7'd1;

    always_comb begin
        w_state   = r_state;
        w_ph_cnt  = r_ph_cnt;
        w_answer  = r_answer;
        w_timeout = r_timeout;
        w_target  = r_target;
        w_timer   = r_timer;
        w_round   = r_round;
        w_score   = r_score;
        w_ok      = r_ok;
        w_bad     = r_bad;
        w_beep    = r_beep;
        w_over    = r_over;

        if (w_tick) begin
            w_ph_cnt = r_ph_cnt + 8'd1;
        end

        unique case (r_state)
            S_IDLE: begin
                w_target = '0;
                w_timer  = '0;
                w_round  = '0;
                w_score  = '0;
                w_ok     = 1'b0;
                w_bad    = 1'b0;
                w_beep   = 1'b0;
                w_over   = 1'b0;
                if (w_st_e) begin
                    w_state  = S_SHOW;
                    w_round  = 3'd1;
                    w_target = w_new_target;
                end
            end
            S_SHOW: begin
                if (w_tick && (r_ph_cnt == c_show_last)) begin
                    w_state = S_ANSWER;
                    w_timer = c_answer_ticks;
                end
            end
            S_ANSWER: begin
`ifdef COUNT_GAME_TIMEOUT_EN
                if (w_tick && (r_timer != 4'd0)) begin
                    w_timer = r_timer - 4'd1;
                end
                // A press on the expiry tick still gets its answer judged
                if (w_st_e) begin
                    w_state   = S_JUDGE;
                    w_answer  = sw;
                    w_timeout = 1'b0;
                end else if (w_tick && (r_timer <= 4'd1)) begin
                    w_state   = S_JUDGE;
                    w_timeout = 1'b1;
                end
`else
                w_timer = c_answer_ticks;
                if (w_st_e) begin
                    w_state   = S_JUDGE;
                    w_answer  = sw;
                    w_timeout = 1'b0;
                end
`endif
            end
            S_JUDGE: begin
                w_state = S_RESULT;
                w_beep  = 1'b1;
                if ((r_answer == r_target) && !r_timeout) begin
                    w_ok = 1'b1;
                    if (r_score != 4'hF) begin
                        w_score = r_score + 4'd1;
                    end
                end else begin
                    w_bad = 1'b1;
                end
            end
            S_RESULT: begin
                if (w_tick) begin
                    w_beep = 1'b0;
                end
                if (w_tick && (r_ph_cnt == c_result_last)) begin
                    if (r_round == c_rounds) begin
                        w_state = S_OVER;
                        w_over  = 1'b1;
                    end else begin
                        w_state  = S_SHOW;
                        w_round  = r_round + 3'd1;
                        w_target = w_new_target;
                        w_ok     = 1'b0;
                        w_bad    = 1'b0;
                    end
                end
            end
            S_OVER: begin
                if (w_st_e) begin
                    w_state  = S_SHOW;
                    w_round  = 3'd1;
                    w_score  = '0;
                    w_target = w_new_target;
                    w_ok     = 1'b0;
                    w_bad    = 1'b0;
                    w_over   = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Phases always start on a fresh tick boundary
        if (w_state != r_state) begin
            w_ph_cnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b1;
            r_lfsr     <= c_lfsr_seed;
            r_tick_cnt <= '0;
            r_ph_cnt   <= '0;
            r_answer   <= '0;
            r_timeout  <= 1'b0;
            r_target   <= '0;
            r_show     <= 1'b0;
            r_timer    <= '0;
            r_round    <= '0;
            r_score    <= '0;
            r_ok       <= 1'b0;
            r_bad      <= 1'b0;
            r_beep     <= 1'b0;
            r_over     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_start_q  <= start;
            r_lfsr     <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            r_tick_cnt <= (w_tick || (w_state != r_state)) ? '0
                                                           : r_tick_cnt + c_tick_w'(1);
            r_ph_cnt   <= w_ph_cnt;
            r_answer   <= w_answer;
            r_timeout  <= w_timeout;
            r_target   <= w_target;
            r_show     <= (w_state == S_SHOW);
            r_timer    <= w_timer;
            r_round    <= w_round;
            r_score    <= w_score;
            r_ok       <= w_ok;
            r_bad      <= w_bad;
            r_beep     <= w_beep;
            r_over     <= w_over;
        end
    end

    assign target = r_target;
    assign show   = r_show;
    assign timer  = r_timer;
    assign round  = r_round;
    assign score  = r_score;
    assign ok     = r_ok;
    assign bad    = r_bad;
    assign beep   = r_beep;
    assign over   = r_over;
    assign state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_count_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_game_ctrl
// Brief    : Scenario bench for count_game_ctrl against a round-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_game_ctrl;
    localparam int TICK_DIV     = 4;
    localparam int SHOW_TICKS   = 3;
    localparam int ANSWER_TICKS = 10;
    localparam int RESULT_TICKS = 2;
    localparam int ROUNDS       = 3;
    localparam int SHOW_CYC     = SHOW_TICKS * TICK_DIV;
    localparam int ANS_CYC      = ANSWER_TICKS * TICK_DIV;
    localparam int RES_CYC      = RESULT_TICKS * TICK_DIV;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [6:0] sw    = '0;
    logic [6:0] target;
    logic       show;
    logic [3:0] timer;
    logic [2:0] round;
    logic [3:0] score;
    logic       ok, bad, beep, over;
    logic [2:0] state;

    int          passed = 0;
    int          total  = 0;
    int unsigned cyc    = 0;
    int          m_score;
    int          m_round;
    logic [6:0]  m_target;

    count_game_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .SHOW_TICKS  (SHOW_TICKS),
        .ANSWER_TICKS(ANSWER_TICKS),
        .RESULT_TICKS(RESULT_TICKS),
        .ROUNDS      (ROUNDS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sw    (sw),
        .target(target),
        .show  (show),
        .timer (timer),
        .round (round),
        .score (score),
        .ok    (ok),
        .bad   (bad),
        .beep  (beep),
        .over  (over),
        .state (state)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset edge; the LFSR value is a function of it
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic logic [6:0] lfsr_adv(input int unsigned n);
        logic [6:0] v;
        v = 7'h5A;
        for (int unsigned i = 0; i < n; i++) v = {v[5:0], v[6] ^ v[5]};
        return v;
    endfunction

    function automatic logic [6:0] tgt_of(input logic [6:0] v);
        return {1'b0, v[5:0]} + 7'd1;
    endfunction

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic show_phase(input int release_at);
        int shows;
        shows = (show === 1'b1) ? 1 : 0;
        for (int k = 1; k <= SHOW_CYC; k++) begin
            if (k == release_at) start = 1'b0;
            step(1);
            if (k < SHOW_CYC && show === 1'b1 && state === 3'd1) shows++;
        end
        total++;
        if (shows != SHOW_CYC) $display("FAIL show_length got=%0d exp=%0d", shows, SHOW_CYC);
        else passed++;
        total++;
        if ({state, show, timer} !== {3'd2, 1'b0, 4'(ANSWER_TICKS)})
            $display("FAIL show_to_answer got state=%0d show=%0d timer=%0d exp state=2 show=0 timer=%0d",
                     state, show, timer, ANSWER_TICKS);
        else passed++;
    endtask

    task automatic result_phase;
        int         beeps;
        int         left;
        logic [6:0] next_tgt;
        next_tgt = tgt_of(lfsr_adv(cyc + RES_CYC - 1));
        beeps = (beep === 1'b1) ? 1 : 0;
        left  = 0;
        for (int r = 1; r < RES_CYC; r++) begin
            step(1);
            if (beep === 1'b1) beeps++;
            if (state !== 3'd4) left++;
        end
        total++;
        if (beeps != TICK_DIV || left != 0)
            $display("FAIL result_beep got beeps=%0d early_exits=%0d exp beeps=%0d early_exits=0",
                     beeps, left, TICK_DIV);
        else passed++;
        step(1);
        if (m_round == ROUNDS) begin
            total++;
            if ({state, over, round, score, show} !== {3'd5, 1'b1, 3'(ROUNDS), 4'(m_score), 1'b0})
                $display("FAIL result_to_over got state=%0d over=%0d round=%0d score=%0d exp 5/1/%0d/%0d",
                         state, over, round, score, ROUNDS, m_score);
            else passed++;
        end else begin
            m_round++;
            m_target = next_tgt;
            total++;
            if ({state, round, target, ok, bad, show, beep} !==
                {3'd1, 3'(m_round), m_target, 1'b0, 1'b0, 1'b1, 1'b0})
                $display("FAIL result_to_show got state=%0d round=%0d target=%0d ok=%0d bad=%0d exp 1/%0d/%0d/0/0",
                         state, round, target, ok, bad, m_round, m_target);
            else passed++;
            show_phase(0);
        end
    endtask

    task automatic answer_phase(input bit correct, input int delay);
        int exp_timer;
        step(delay);
`ifdef COUNT_GAME_TIMEOUT_EN
        exp_timer = ANSWER_TICKS - delay / TICK_DIV;
`else
        exp_timer = ANSWER_TICKS;
`endif
        total++;
        if (state !== 3'd2 || timer !== 4'(exp_timer))
            $display("FAIL answer_timer got state=%0d timer=%0d exp state=2 timer=%0d", state, timer, exp_timer);
        else passed++;
        sw    = correct ? m_target : (m_target ^ 7'($urandom_range(1, 127)));
        start = 1'b1;
        step(1);
        start = 1'b0;
        sw    = 7'($urandom);
        total++;
        if (state !== 3'd3) $display("FAIL answer_to_judge got=%0d exp=3", state);
        else passed++;
        step(1);
        if (correct && m_score < 15) m_score++;
        total++;
        if ({state, ok, bad, beep, score} !== {3'd4, correct, !correct, 1'b1, 4'(m_score)})
            $display("FAIL verdict got state=%0d ok=%0d bad=%0d beep=%0d score=%0d exp 4/%0d/%0d/1/%0d",
                     state, ok, bad, beep, score, correct, !correct, m_score);
        else passed++;
        result_phase();
    endtask

    task automatic restart_game;
        m_target = tgt_of(lfsr_adv(cyc));
        m_round  = 1;
        m_score  = 0;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
        total++;
        if ({state, round, score, over, target} !== {3'd1, 3'd1, 4'd0, 1'b0, m_target})
            $display("FAIL restart got state=%0d round=%0d score=%0d over=%0d target=%0d exp 1/1/0/0/%0d",
                     state, round, score, over, target, m_target);
        else passed++;
        show_phase(0);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sw = '0;
        step(3);
        total++;
        if ({target, show, timer, round, score, ok, bad, beep, over, state} !== 26'd0)
            $display("FAIL reset_outputs got=%h exp=0",
                     {target, show, timer, round, score, ok, bad, beep, over, state});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_start_show;
        step($urandom_range(1, 7));
        total++;
        if (state !== 3'd0) $display("FAIL idle_wait got=%0d exp=0", state);
        else passed++;
        m_target = tgt_of(lfsr_adv(cyc));
        m_round  = 1;
        m_score  = 0;
        start    = 1'b1;
        step(1);
        total++;
        if ({state, round, score, target} !== {3'd1, 3'd1, 4'd0, m_target})
            $display("FAIL start_to_show got state=%0d round=%0d score=%0d target=%0d exp 1/1/0/%0d",
                     state, round, score, target, m_target);
        else passed++;
        total++;
        if (target < 7'd1 || target > 7'd64) $display("FAIL target_range got=%0d exp 1..64", target);
        else passed++;
        show_phase(10);
    endtask

    task automatic test_correct;
        answer_phase(1'b1, $urandom_range(0, 30));
    endtask

    task automatic test_wrong;
        answer_phase(1'b0, $urandom_range(0, 30));
    endtask

    task automatic test_timeout;
`ifdef COUNT_GAME_TIMEOUT_EN
        int errs;
        errs = 0;
        for (int k = 0; k < ANS_CYC; k++) begin
            if (state !== 3'd2 || timer !== 4'(ANSWER_TICKS - k / TICK_DIV)) errs++;
            step(1);
        end
        total++;
        if (errs != 0) $display("FAIL timer_countdown got errors=%0d exp=0", errs);
        else passed++;
        total++;
        if ({state, timer} !== {3'd3, 4'd0})
            $display("FAIL timeout_to_judge got state=%0d timer=%0d exp 3/0", state, timer);
        else passed++;
        step(1);
        total++;
        if ({state, ok, bad, beep, score} !== {3'd4, 1'b0, 1'b1, 1'b1, 4'(m_score)})
            $display("FAIL timeout_verdict got state=%0d ok=%0d bad=%0d beep=%0d score=%0d exp 4/0/1/1/%0d",
                     state, ok, bad, beep, score, m_score);
        else passed++;
        result_phase();
`else
        step(1000);
        total++;
        if ({state, timer} !== {3'd2, 4'(ANSWER_TICKS)})
            $display("FAIL no_timeout_wait got state=%0d timer=%0d exp 2/%0d", state, timer, ANSWER_TICKS);
        else passed++;
        answer_phase(1'b1, 0);
`endif
    endtask

    task automatic test_over_restart;
        step($urandom_range(1, 5));
        total++;
        if ({state, over, score} !== {3'd5, 1'b1, 4'(m_score)})
            $display("FAIL over_hold got state=%0d over=%0d score=%0d exp 5/1/%0d", state, over, score, m_score);
        else passed++;
        restart_game();
    endtask

    task automatic test_three_correct;
        for (int i = 0; i < ROUNDS; i++) answer_phase(1'b1, $urandom_range(0, 30));
        total++;
        if ({over, score, round} !== {1'b1, 4'd3, 3'd3})
            $display("FAIL three_correct got over=%0d score=%0d round=%0d exp 1/3/3", over, score, round);
        else passed++;
    endtask

    task automatic test_random_game;
        step($urandom_range(1, 5));
        restart_game();
        for (int i = 0; i < ROUNDS; i++) answer_phase(1'($urandom_range(0, 1)), $urandom_range(0, 30));
    endtask

    task automatic test_reset_mid_show;
        step(2);
        start = 1'b1;
        step(1);
        step($urandom_range(1, 8));
        rst = 1'b1;
        step(1);
        total++;
        if ({target, show, timer, round, score, ok, bad, beep, over, state} !== 26'd0)
            $display("FAIL reset_mid_show got=%h exp=0",
                     {target, show, timer, round, score, ok, bad, beep, over, state});
        else passed++;
        rst = 1'b0;
        step(20);
        total++;
        if (state !== 3'd0) $display("FAIL held_start_ignored got=%0d exp=0", state);
        else passed++;
        start = 1'b0;
        step(2);
        m_target = tgt_of(lfsr_adv(cyc));
        start = 1'b1;
        step(1);
        start = 1'b0;
        total++;
        if ({state, round, target} !== {3'd1, 3'd1, m_target})
            $display("FAIL start_after_release got state=%0d round=%0d target=%0d exp 1/1/%0d",
                     state, round, target, m_target);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_start_show;
        test_correct;
        test_wrong;
        test_timeout;
        test_over_restart;
        test_three_correct;
        test_random_game;
        test_reset_mid_show;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
